// File: rtl/keypad_insn_in_if.sv
// rtl/keypad_insn_in_if.sv - keypad/ENTER inputs and instruction word outputs of keypad_insn_in
//
// Purpose : bundles the keypad scan lines, the ENTER button and the
//           assembled-instruction outputs into one port.
// Signals : col         [3:0]  keypad columns, active-low, asynchronous
//           enter              ENTER button, active-high, asynchronous, bouncy
//           row         [3:0]  keypad rows, active-low one-hot drive
//           insn        [15:0] assembled instruction word, newest digit in [3:0]
//           insn_valid         one-cycle pulse, insn stable while high
//           digit_count [2:0]  digits entered since last ENTER, saturates at 4
// Modports: master = keypad_insn_in, slave = keypad/loader side

interface keypad_insn_in_if;
   logic [3:0]  col;
   logic        enter;
   logic [3:0]  row;
   logic [15:0] insn;
   logic        insn_valid;
   logic [2:0]  digit_count;

   modport master (
      input  col,
      input  enter,
      output row,
      output insn,
      output insn_valid,
      output digit_count
   );

   modport slave (
      output col,
      output enter,
      input  row,
      input  insn,
      input  insn_valid,
      input  digit_count
   );
endinterface

// File: rtl/keypad_insn_in.sv
// rtl/keypad_insn_in.sv - 4x4 hex keypad scanner/debouncer assembling a 16-bit instruction word
//
// Purpose : scans an active-low 4x4 hex keypad, debounces presses, shifts
//           each accepted digit into a 16-bit word and pulses insn_valid
//           once per debounced ENTER press.
// Params  : SCAN_MSB - row slot is 2^(SCAN_MSB+1) clk cycles
//           DB_BITS  - debounce window is 2^DB_BITS stable cycles
// Ports   : clk - system clock
//           res - asynchronous active-high reset
//           kp  - keypad_insn_in_if.master (col/enter in, row/insn/insn_valid/digit_count out)
// Option  : INSN_IN_AUTOCLR_EN - when defined, insn is cleared the cycle
//           after insn_valid so every instruction starts from a blank word.

module keypad_insn_in #(
   parameter int SCAN_MSB = 16,
   parameter int DB_BITS  = 18
) (
   input logic               clk,
   input logic               res,
   keypad_insn_in_if.master  kp
);

   typedef enum logic [1:0] {
      KP_SCAN     = 2'd0,
      KP_DEBOUNCE = 2'd1,
      KP_HOLD     = 2'd2
   } kp_state_t;

   typedef enum logic [1:0] {
      EN_IDLE  = 2'd0,
      EN_DB    = 2'd1,
      EN_REARM = 2'd2
   } en_state_t;

   logic [3:0]          r_col_s1;
   logic [3:0]          r_col_s2;
   logic                r_en_s1;
   logic                r_en_s2;
   logic [SCAN_MSB:0]   r_scan_cnt;
   logic [1:0]          r_row_idx;
   logic [1:0]          r_col_idx;
   logic [3:0]          r_pat;
   kp_state_t           r_kp_state;
   logic [DB_BITS-1:0]  r_kp_cnt;
   en_state_t           r_en_state;
   logic [DB_BITS-1:0]  r_en_cnt;
   logic [15:0]         r_insn;
   logic                r_insn_valid;
   logic [2:0]          r_digit_count;

   logic                w_slot_end;
   logic                w_single_low;
   logic [1:0]          w_col_idx;
   logic [3:0]          w_key;
   kp_state_t           w_kp_state_nx;
   logic [DB_BITS-1:0]  w_kp_cnt_nx;
   logic                w_latch;
   logic                w_row_adv;
   logic                w_accept;
   en_state_t           w_en_state_nx;
   logic [DB_BITS-1:0]  w_en_cnt_nx;
   logic                w_fire;
   logic [15:0]         w_insn_base;
   logic [15:0]         w_insn_nx;
   logic [2:0]          w_count_base;
   logic [2:0]          w_count_nx;

   assign w_slot_end = &r_scan_cnt;
   assign w_key      = {r_row_idx, r_col_idx};

   assign kp.row         = ~(4'b0001 << r_row_idx);
   assign kp.insn        = r_insn;
   assign kp.insn_valid  = r_insn_valid;
   assign kp.digit_count = r_digit_count;

   // Only a single low column is a usable key; two or more low columns on
   // one row are ghosting/multi-press and are ignored.
   always_comb begin
      w_single_low = 1'b1;
      w_col_idx    = 2'd0;
      case (r_col_s2)
         4'b1110: w_col_idx = 2'd0;
         4'b1101: w_col_idx = 2'd1;
         4'b1011: w_col_idx = 2'd2;
         4'b0111: w_col_idx = 2'd3;
         default: w_single_low = 1'b0;
      endcase
   end

   // Keypad FSM: the row drive is frozen outside SCAN because row_idx only
   // advances on a SCAN slot end that found no single key.
   always_comb begin
      w_kp_state_nx = r_kp_state;
      w_kp_cnt_nx   = r_kp_cnt;
      w_latch       = 1'b0;
      w_row_adv     = 1'b0;
      w_accept      = 1'b0;
      case (r_kp_state)
         KP_SCAN: begin
            if (w_slot_end) begin
               if (w_single_low) begin
                  w_latch       = 1'b1;
                  w_kp_cnt_nx   = '0;
                  w_kp_state_nx = KP_DEBOUNCE;
               end else begin
                  w_row_adv = 1'b1;
               end
            end
         end
         KP_DEBOUNCE: begin
            if (r_col_s2 == r_pat) begin
               w_kp_cnt_nx = r_kp_cnt + 1'b1;
               if (&r_kp_cnt) begin
                  w_accept      = 1'b1;
                  w_kp_state_nx = KP_HOLD;
               end
            end else begin
               w_kp_cnt_nx   = '0;
               w_kp_state_nx = KP_SCAN;
            end
         end
         KP_HOLD: begin
            if (r_col_s2 == 4'hF) begin
               w_kp_cnt_nx = r_kp_cnt + 1'b1;
               if (&r_kp_cnt) begin
                  w_kp_state_nx = KP_SCAN;
               end
            end else begin
               w_kp_cnt_nx = '0;
            end
         end
         default: begin
            w_kp_cnt_nx   = '0;
            w_kp_state_nx = KP_SCAN;
         end
      endcase
   end

   // ENTER FSM: IDLE is only reached after a stable-low window, so a high
   // level seen in IDLE is a genuine rising edge.
   always_comb begin
      w_en_state_nx = r_en_state;
      w_en_cnt_nx   = r_en_cnt;
      w_fire        = 1'b0;
      case (r_en_state)
         EN_IDLE: begin
            if (r_en_s2) begin
               w_en_cnt_nx   = '0;
               w_en_state_nx = EN_DB;
            end
         end
         EN_DB: begin
            if (r_en_s2) begin
               w_en_cnt_nx = r_en_cnt + 1'b1;
               if (&r_en_cnt) begin
                  w_fire        = 1'b1;
                  w_en_state_nx = EN_REARM;
               end
            end else begin
               w_en_cnt_nx   = '0;
               w_en_state_nx = EN_IDLE;
            end
         end
         EN_REARM: begin
            if (!r_en_s2) begin
               w_en_cnt_nx = r_en_cnt + 1'b1;
               if (&r_en_cnt) begin
                  w_en_state_nx = EN_IDLE;
               end
            end else begin
               w_en_cnt_nx = '0;
            end
         end
         default: begin
            w_en_cnt_nx   = '0;
            w_en_state_nx = EN_IDLE;
         end
      endcase
   end

   // The word/count seen by a digit accept is the post-ENTER one, so an
   // accept coinciding with insn_valid lands on top of the cleared state.
   always_comb begin
      w_count_base = r_insn_valid ? 3'd0 : r_digit_count;
`ifdef INSN_IN_AUTOCLR_EN
      w_insn_base  = r_insn_valid ? 16'h0000 : r_insn;
`else
      w_insn_base  = r_insn;
`endif
      w_insn_nx    = w_insn_base;
      w_count_nx   = w_count_base;
      if (w_accept) begin
         w_insn_nx  = {w_insn_base[11:0], w_key};
         w_count_nx = (w_count_base == 3'd4) ? 3'd4 : w_count_base + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_col_s1      <= 4'hF;
         r_col_s2      <= 4'hF;
         r_en_s1       <= 1'b0;
         r_en_s2       <= 1'b0;
         r_scan_cnt    <= '0;
         r_row_idx     <= 2'd0;
         r_col_idx     <= 2'd0;
         r_pat         <= 4'hF;
         r_kp_state    <= KP_SCAN;
         r_kp_cnt      <= '0;
         r_en_state    <= EN_IDLE;
         r_en_cnt      <= '0;
         r_insn        <= 16'h0000;
         r_insn_valid  <= 1'b0;
         r_digit_count <= 3'd0;
      end else begin
         r_col_s1      <= kp.col;
         r_col_s2      <= r_col_s1;
         r_en_s1       <= kp.enter;
         r_en_s2       <= r_en_s1;
         r_scan_cnt    <= r_scan_cnt + 1'b1;
         if (w_row_adv) begin
            r_row_idx <= r_row_idx + 2'd1;
         end
         if (w_latch) begin
            r_col_idx <= w_col_idx;
            r_pat     <= r_col_s2;
         end
         r_kp_state    <= w_kp_state_nx;
         r_kp_cnt      <= w_kp_cnt_nx;
         r_en_state    <= w_en_state_nx;
         r_en_cnt      <= w_en_cnt_nx;
         r_insn        <= w_insn_nx;
         r_insn_valid  <= w_fire;
         r_digit_count <= w_count_nx;
      end
   end

endmodule
